// File: rtl/ym2610_rom_responder.sv
// ym2610_rom_responder: serves YM2610 ADPCM-A/B ROM reads from a shared byte memory port.
// The ADPCM-B channel is built only when YM2610_PCM_B_EN is defined.
module ym2610_rom_responder #(
   parameter logic [23:0] B_OFFSET = 24'h000000
) (
   input  logic        clk,
   input  logic        ic_n,
   input  logic        rmpx,
   input  logic        roe,
   input  logic [7:0]  rad_in,
   input  logic [1:0]  ra9_8,
   input  logic [3:0]  ra23_20,
   output logic [7:0]  rad_out,
   output logic        rad_oe,
   input  logic        pmpx,
   input  logic        poe,
   input  logic [7:0]  pad_in,
   input  logic [3:0]  pa11_8,
   output logic [7:0]  pad_out,
   output logic        pad_oe,
   output logic        mem_req,
   output logic        mem_sel,
   output logic [23:0] mem_addr,
   input  logic        mem_ack,
   input  logic [7:0]  mem_rdata,
   output logic        a_late,
   output logic        b_late
);
   localparam logic [1:0] IDLE = 2'd0, BUSY_A = 2'd1, BUSY_B = 2'd2;
   logic [1:0]  state;
   logic [23:0] addr_r, a_addr, b_addr;
   logic        rmpx_q, rmpx_p, roe_q, roe_p;
   logic [7:0]  rad_q;
   logic [1:0]  ra9_8_q;
   logic [3:0]  ra23_20_q;
   logic        pend_a, valid_a, late_a, redo_a, disc_a, pend_b;
   logic [7:0]  data_a;
   logic        ack_a, fall_a, rise_a;
   assign ack_a  = mem_ack && (state == BUSY_A);
   assign fall_a = roe_p && !roe_q;
   assign rise_a = !roe_p && roe_q;
   // redo: superseded while in flight, so the ack is dropped and the new address relaunched
   // disc: enable window closed while pending, so the ack is dropped
   always_ff @(posedge clk) begin
      if (!ic_n) begin
         rmpx_q <= 1'b0; rmpx_p <= 1'b0; roe_q <= 1'b1; roe_p <= 1'b1;
         rad_q <= '0; ra9_8_q <= '0; ra23_20_q <= '0; a_addr <= '0;
         pend_a <= 1'b0; valid_a <= 1'b0; late_a <= 1'b0; redo_a <= 1'b0; disc_a <= 1'b0;
         data_a <= '0;
      end else begin
         rmpx_q <= rmpx; rmpx_p <= rmpx_q; roe_q <= roe; roe_p <= roe_q;
         rad_q <= rad_in; ra9_8_q <= ra9_8; ra23_20_q <= ra23_20;
         if (rmpx_q && !rmpx_p) a_addr[9:0] <= {ra9_8_q, rad_q};
         if (!rmpx_q && rmpx_p) a_addr[23:10] <= {ra23_20_q, ra9_8_q, rad_q};
         if (ack_a) begin
            if (!redo_a && !disc_a) begin
               data_a <= mem_rdata;
               valid_a <= 1'b1;
            end
            pend_a <= redo_a;
            redo_a <= 1'b0;
            disc_a <= 1'b0;
         end
         // valid also drops once the window closes so a stale byte never shows on the next fall
         if (rise_a) begin
            valid_a <= 1'b0;
            if (pend_a) late_a <= 1'b1;
            if (pend_a && !ack_a) disc_a <= 1'b1;
         end
         if (fall_a) begin
            pend_a <= 1'b1;
            valid_a <= 1'b0;
            disc_a <= 1'b0;
            redo_a <= pend_a && (state == BUSY_A) && !mem_ack;
            if (pend_a) late_a <= 1'b1;
         end
      end
   end
   assign rad_oe  = !roe_q && valid_a;
   assign rad_out = data_a;
   assign a_late  = late_a;
`ifdef YM2610_PCM_B_EN
   logic       pmpx_q, pmpx_p, poe_q, poe_p;
   logic [7:0] pad_q;
   logic [3:0] pa11_8_q;
   logic       valid_b, late_b, redo_b, disc_b;
   logic [7:0] data_b;
   logic       ack_b, fall_b, rise_b;
   assign ack_b  = mem_ack && (state == BUSY_B);
   assign fall_b = poe_p && !poe_q;
   assign rise_b = !poe_p && poe_q;
   always_ff @(posedge clk) begin
      if (!ic_n) begin
         pmpx_q <= 1'b0; pmpx_p <= 1'b0; poe_q <= 1'b1; poe_p <= 1'b1;
         pad_q <= '0; pa11_8_q <= '0; b_addr <= '0;
         pend_b <= 1'b0; valid_b <= 1'b0; late_b <= 1'b0; redo_b <= 1'b0; disc_b <= 1'b0;
         data_b <= '0;
      end else begin
         pmpx_q <= pmpx; pmpx_p <= pmpx_q; poe_q <= poe; poe_p <= poe_q;
         pad_q <= pad_in; pa11_8_q <= pa11_8;
         if (pmpx_q && !pmpx_p) b_addr[11:0] <= {pa11_8_q, pad_q};
         if (!pmpx_q && pmpx_p) b_addr[23:12] <= {pa11_8_q, pad_q};
         if (ack_b) begin
            if (!redo_b && !disc_b) begin
               data_b <= mem_rdata;
               valid_b <= 1'b1;
            end
            pend_b <= redo_b;
            redo_b <= 1'b0;
            disc_b <= 1'b0;
         end
         if (rise_b) begin
            valid_b <= 1'b0;
            if (pend_b) late_b <= 1'b1;
            if (pend_b && !ack_b) disc_b <= 1'b1;
         end
         if (fall_b) begin
            pend_b <= 1'b1;
            valid_b <= 1'b0;
            disc_b <= 1'b0;
            redo_b <= pend_b && (state == BUSY_B) && !mem_ack;
            if (pend_b) late_b <= 1'b1;
         end
      end
   end
   assign pad_oe  = !poe_q && valid_b;
   assign pad_out = data_b;
   assign b_late  = late_b;
   assign mem_sel = (state == BUSY_B);
`else
   logic unused_b;
   assign unused_b = ^{pmpx, poe, pad_in, pa11_8};
   assign pend_b   = 1'b0;
   assign b_addr   = '0;
   assign pad_oe   = 1'b0;
   assign pad_out  = '0;
   assign b_late   = 1'b0;
   assign mem_sel  = 1'b0;
`endif
   // the address is captured at launch so it stays stable while the bus re-latches
   always_ff @(posedge clk) begin
      if (!ic_n) begin
         state <= IDLE;
         addr_r <= '0;
      end else if (state == IDLE) begin
         if (pend_a) begin
            state <= BUSY_A;
            addr_r <= a_addr;
         end else if (pend_b) begin
            state <= BUSY_B;
            addr_r <= b_addr + B_OFFSET;
         end
      end else if (mem_ack) begin
         state <= IDLE;
      end
   end
   assign mem_req  = (state != IDLE);
   assign mem_addr = addr_r;
endmodule

// File: tb/tb_ym2610_rom_responder.sv
// tb_ym2610_rom_responder: directed scoreboard bench for the YM2610 ROM responder.
module tb_ym2610_rom_responder;
   typedef struct packed {
      logic        sel;
      logic [23:0] addr;
      logic [7:0]  data;
   } item_t;
   logic        clk = 1'b0, ic_n = 1'b0, rmpx = 1'b0, roe = 1'b1, pmpx = 1'b0, poe = 1'b1;
   logic [7:0]  rad_in = '0, pad_in = '0, mem_rdata = '0;
   logic [1:0]  ra9_8 = '0;
   logic [3:0]  ra23_20 = '0, pa11_8 = '0;
   logic        mem_ack = 1'b0;
   logic [7:0]  rad_out, pad_out;
   logic        rad_oe, pad_oe, mem_req, mem_sel, a_late, b_late;
   logic [23:0] mem_addr;
   item_t       exp_q[$], done_q[$];
   int          n_tests = 0, n_fail = 0;
   always #5 clk = ~clk;
   ym2610_rom_responder #(.B_OFFSET(24'h100000)) dut (
      .clk(clk), .ic_n(ic_n), .rmpx(rmpx), .roe(roe), .rad_in(rad_in), .ra9_8(ra9_8),
      .ra23_20(ra23_20), .rad_out(rad_out), .rad_oe(rad_oe), .pmpx(pmpx), .poe(poe),
      .pad_in(pad_in), .pa11_8(pa11_8), .pad_out(pad_out), .pad_oe(pad_oe),
      .mem_req(mem_req), .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_ack(mem_ack),
      .mem_rdata(mem_rdata), .a_late(a_late), .b_late(b_late)
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic drive_a(input logic [23:0] ad);
      @(negedge clk);
      rad_in = ad[7:0]; ra9_8 = ad[9:8]; rmpx = 1'b1;
      repeat (4) @(negedge clk);
      rad_in = ad[17:10]; ra9_8 = ad[19:18]; ra23_20 = ad[23:20]; rmpx = 1'b0;
      repeat (4) @(negedge clk);
   endtask
   task automatic drive_b(input logic [23:0] ad);
      @(negedge clk);
      pad_in = ad[7:0]; pa11_8 = ad[11:8]; pmpx = 1'b1;
      repeat (4) @(negedge clk);
      pad_in = ad[19:12]; pa11_8 = ad[23:20]; pmpx = 1'b0;
      repeat (4) @(negedge clk);
   endtask
   task automatic wait_req();
      for (int i = 0; i < 50 && !mem_req; i++) @(negedge clk);
      chk("req_seen", {31'd0, mem_req}, 32'd1);
   endtask
   task automatic serve(input int dly, input bit keep);
      item_t it;
      wait_req();
      chk("sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
         it = exp_q.pop_front();
         chk("mem_sel", {31'd0, mem_sel}, {31'd0, it.sel});
         chk("mem_addr", {8'd0, mem_addr}, {8'd0, it.addr});
         repeat (dly) @(negedge clk);
         chk("req_hold", {6'd0, mem_req, mem_sel, mem_addr}, {6'd0, 1'b1, it.sel, it.addr});
         mem_ack = 1'b1; mem_rdata = it.data;
         @(negedge clk);
         mem_ack = 1'b0; mem_rdata = '0;
         if (keep) done_q.push_back(it);
      end
   endtask
   task automatic check_out(input bit b);
      item_t it;
      chk("done_nonempty", {31'd0, done_q.size() != 0}, 32'd1);
      if (done_q.size() != 0) begin
         it = done_q.pop_front();
         chk(b ? "pad_oe" : "rad_oe", {31'd0, b ? pad_oe : rad_oe}, 32'd1);
         chk(b ? "pad_out" : "rad_out", {24'd0, b ? pad_out : rad_out}, {24'd0, it.data});
      end
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end
   initial begin
      bit any_b, any_oe;
      repeat (3) @(negedge clk);
      chk("rst_req", {31'd0, mem_req}, 32'd0);
      chk("rst_addr", {8'd0, mem_addr}, 32'd0);
      chk("rst_oe", {30'd0, rad_oe, pad_oe}, 32'd0);
      chk("rst_out", {16'd0, rad_out, pad_out}, 32'd0);
      chk("rst_late", {30'd0, a_late, b_late}, 32'd0);
      chk("rst_sel", {31'd0, mem_sel}, 32'd0);
      ic_n = 1'b1;
      @(negedge clk);
      drive_a(24'h123456);
      exp_q.push_back({1'b0, 24'h123456, 8'hA5});
      roe = 1'b0;
      serve(3, 1);
      repeat (2) @(negedge clk);
      check_out(0);
      chk("a_late_clean", {31'd0, a_late}, 32'd0);
      roe = 1'b1;
      repeat (3) @(negedge clk);
      chk("rad_oe_off", {31'd0, rad_oe}, 32'd0);
`ifdef YM2610_PCM_B_EN
      drive_a(24'h000200);
      drive_b(24'h0ABCDE);
      exp_q.push_back({1'b0, 24'h000200, 8'h11});
      exp_q.push_back({1'b1, 24'h1ABCDE, 8'h5A});
      roe = 1'b0; poe = 1'b0;
      serve(2, 1);
      serve(2, 1);
      repeat (2) @(negedge clk);
      check_out(0);
      check_out(1);
      roe = 1'b1; poe = 1'b1;
      repeat (3) @(negedge clk);
      drive_b(24'hF00001);
      exp_q.push_back({1'b1, 24'h000001, 8'hC3});
      poe = 1'b0;
      serve(1, 1);
      repeat (2) @(negedge clk);
      check_out(1);
      chk("b_late_clean", {31'd0, b_late}, 32'd0);
      poe = 1'b1;
      repeat (3) @(negedge clk);
`else
      drive_b(24'h0ABCDE);
      any_b = 1'b0; any_oe = 1'b0;
      for (int i = 0; i < 24; i++) begin
         poe = i[2];
         pmpx = i[1];
         @(negedge clk);
         any_b |= mem_req && mem_sel;
         any_oe |= pad_oe;
      end
      poe = 1'b1; pmpx = 1'b0;
      chk("b_no_req", {31'd0, any_b}, 32'd0);
      chk("b_no_oe", {31'd0, any_oe}, 32'd0);
      chk("b_idle_bus", {31'd0, mem_req}, 32'd0);
      chk("b_late_off", {31'd0, b_late}, 32'd0);
      chk("pad_out_off", {24'd0, pad_out}, 32'd0);
`endif
      drive_a(24'h000FF0);
      exp_q.push_back({1'b0, 24'h000FF0, 8'h77});
      roe = 1'b0;
      repeat (8) @(negedge clk);
      chk("a_wait_oe", {31'd0, rad_oe}, 32'd0);
      roe = 1'b1;
      repeat (4) @(negedge clk);
      serve(0, 0);
      repeat (2) @(negedge clk);
      chk("late_no_oe", {31'd0, rad_oe}, 32'd0);
      chk("a_late_set", {31'd0, a_late}, 32'd1);
      drive_a(24'hFFFFFF);
      exp_q.push_back({1'b0, 24'hFFFFFF, 8'h3C});
      roe = 1'b0;
      serve(1, 1);
      repeat (2) @(negedge clk);
      check_out(0);
      chk("a_late_sticky", {31'd0, a_late}, 32'd1);
      roe = 1'b1;
      repeat (3) @(negedge clk);
      drive_a(24'h0000AA);
      roe = 1'b0;
      wait_req();
      chk("busy_addr", {8'd0, mem_addr}, 32'h0000AA);
      ic_n = 1'b0; roe = 1'b1;
      @(negedge clk);
      chk("rst_drop_req", {31'd0, mem_req}, 32'd0);
      mem_ack = 1'b1; mem_rdata = 8'hEE;
      @(negedge clk);
      ic_n = 1'b1;
      repeat (3) @(negedge clk);
      mem_ack = 1'b0; mem_rdata = '0;
      chk("post_rst_req", {31'd0, mem_req}, 32'd0);
      chk("post_rst_oe", {31'd0, rad_oe}, 32'd0);
      chk("post_rst_late", {31'd0, a_late}, 32'd0);
      drive_a(24'h00ABCD);
      exp_q.push_back({1'b0, 24'h00ABCD, 8'h99});
      exp_q.push_back({1'b0, 24'h054321, 8'h66});
      roe = 1'b0;
      wait_req();
      drive_a(24'h054321);
      roe = 1'b1;
      repeat (2) @(negedge clk);
      roe = 1'b0;
      repeat (2) @(negedge clk);
      serve(0, 0);
      serve(1, 1);
      repeat (2) @(negedge clk);
      check_out(0);
      chk("restart_late", {31'd0, a_late}, 32'd1);
      roe = 1'b1;
      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
